// File: rtl/sel_decim_buffer_pkg.sv
// Shared definitions for the selector delay/decimation buffer:
// default geometry, the phase-event encoding and the phase-width helper.
package sel_decim_buffer_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_DELAY = 2;
    localparam int DEFAULT_RATIO = 3;

    // What the phase counter does at a given clock edge, in priority order.
    typedef enum logic [1:0] {
        EV_SYNC    = 2'd0,  // re-align: phase to 0, no sample
        EV_HOLD    = 2'd1,  // disabled: phase frozen, strobes low
        EV_SAMPLE  = 2'd2,  // last phase of the period: wrap and sample
        EV_ADVANCE = 2'd3   // ordinary counting edge
    } phase_event_e;

    // Bits needed to hold phases 0..ratio-1 (never less than one bit).
    function automatic int phase_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/sel_decim_buffer_delay_line.sv
// Register chain ahead of the sampler. The sampler register in the top level
// is the final stage of the selector pipeline, so this chain holds DELAY-1
// registers and the top-level sel_out register completes the DELAY-cycle
// latency. With DELAY=1 the chain is empty and sel_in goes straight through.
module sel_decim_buffer_delay_line #(
    parameter int WIDTH = 1,
    parameter int DELAY = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] sel_in,
    output logic [WIDTH-1:0] tail
);

    genvar gi;

    generate
        if (DELAY < 1 || WIDTH < 1) begin : g_bad_params
            $error("sel_decim_buffer_delay_line: DELAY and WIDTH must be >= 1");
        end

        if (DELAY == 1) begin : g_passthrough
            assign tail = sel_in;
        end else begin : g_chain
            for (gi = 0; gi < DELAY - 1; gi++) begin : g_stage
                logic [WIDTH-1:0] q_reg;
                logic [WIDTH-1:0] q_next;

                if (gi == 0) begin : g_head
                    assign q_next = sel_in;
                end else begin : g_body
                    assign q_next = g_stage[gi-1].q_reg;
                end

                // Each stage shifts unconditionally; only reset clears it.
                always_ff @(posedge clk or negedge reset_L) begin
                    if (!reset_L) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= q_next;
                    end
                end
            end

            assign tail = g_stage[DELAY-2].q_reg;
        end
    endgenerate

endmodule

// File: rtl/sel_decim_buffer.sv
// Selector delay/decimation buffer: delays a selector bus and re-samples it
// once every RATIO enabled clocks, with enable, phase re-sync, a sample
// strobe, a change flag and the current phase exposed.
module sel_decim_buffer
    import sel_decim_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DELAY = DEFAULT_DELAY,
    parameter int RATIO = DEFAULT_RATIO,
    parameter int CW    = phase_bits(RATIO)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] sel_in,
    output logic [WIDTH-1:0] sel_out,
    output logic             out_valid,
    output logic             sel_changed,
    output logic [CW-1:0]    phase
);

    localparam logic [CW-1:0] LAST_PHASE = CW'(RATIO - 1);
    localparam logic [CW-1:0] PHASE_ONE  = CW'(1);

    generate
        if (RATIO < 2 || DELAY < 1 || WIDTH < 1) begin : g_bad_params
            $error("sel_decim_buffer: need RATIO >= 2, DELAY >= 1, WIDTH >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] tail;
    logic [CW-1:0]    phase_reg;
    logic [WIDTH-1:0] sel_out_reg;
    logic             out_valid_reg;
    logic             sel_changed_reg;
    phase_event_e     phase_event;

    sel_decim_buffer_delay_line #(
        .WIDTH (WIDTH),
        .DELAY (DELAY)
    ) u_delay_line (
        .clk     (clk),
        .reset_L (reset_L),
        .sel_in  (sel_in),
        .tail    (tail)
    );

    // Decode this edge's action; sync outranks enable, which outranks wrap.
    always_comb begin
        phase_event = EV_ADVANCE;
        if (sync) begin
            phase_event = EV_SYNC;
        end else if (!en) begin
            phase_event = EV_HOLD;
        end else if (phase_reg == LAST_PHASE) begin
            phase_event = EV_SAMPLE;
        end
    end

    // Phase counter, sampler and strobes; sel_out only moves on a sample.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            phase_reg       <= '0;
            sel_out_reg     <= '0;
            out_valid_reg   <= 1'b0;
            sel_changed_reg <= 1'b0;
        end else begin
            unique case (phase_event)
                EV_SYNC: begin
                    phase_reg       <= '0;
                    out_valid_reg   <= 1'b0;
                    sel_changed_reg <= 1'b0;
                end
                EV_HOLD: begin
                    out_valid_reg   <= 1'b0;
                    sel_changed_reg <= 1'b0;
                end
                EV_SAMPLE: begin
                    phase_reg       <= '0;
                    sel_out_reg     <= tail;
                    out_valid_reg   <= 1'b1;
                    sel_changed_reg <= (tail != sel_out_reg);
                end
                default: begin
                    phase_reg       <= phase_reg + PHASE_ONE;
                    out_valid_reg   <= 1'b0;
                    sel_changed_reg <= 1'b0;
                end
            endcase
        end
    end

    assign sel_out     = sel_out_reg;
    assign out_valid   = out_valid_reg;
    assign sel_changed = sel_changed_reg;
    assign phase       = phase_reg;

endmodule

// File: tb/tb_sel_decim_buffer.sv
// Bench for sel_decim_buffer: two configurations driven by shared stimulus,
// each compared every cycle against a behavioural model built from an
// input history and a count of enabled edges since the last re-alignment.
module tb_sel_decim_buffer;

    logic       clk;
    logic       reset_L;
    logic       en;
    logic       sync;
    logic [3:0] sel_in;

    // Configuration A: WIDTH=2, DELAY=2, RATIO=3
    logic [1:0] so_a;
    logic       v_a;
    logic       ch_a;
    logic [1:0] ph_a;
    // Configuration B: WIDTH=4, DELAY=3, RATIO=5
    logic [3:0] so_b;
    logic       v_b;
    logic       ch_b;
    logic [2:0] ph_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    logic [3:0] hist [0:1023];
    int         edge_n;
    int         cnt_a, cnt_b;
    logic [3:0] mso_a, mso_b;
    logic       mv_a, mv_b, mch_a, mch_b;

    sel_decim_buffer #(.WIDTH(2), .DELAY(2), .RATIO(3)) dut_a (
        .clk(clk), .reset_L(reset_L), .en(en), .sync(sync),
        .sel_in(sel_in[1:0]), .sel_out(so_a), .out_valid(v_a),
        .sel_changed(ch_a), .phase(ph_a)
    );

    sel_decim_buffer #(.WIDTH(4), .DELAY(3), .RATIO(5)) dut_b (
        .clk(clk), .reset_L(reset_L), .en(en), .sync(sync),
        .sel_in(sel_in), .sel_out(so_b), .out_valid(v_b),
        .sel_changed(ch_b), .phase(ph_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at edge e takes the sel_in value presented at edge e-d+1
    // (zero if that precedes the last reset release).
    task automatic model(input int r, input int d, input logic [3:0] mask, input int e,
                         input logic s, input logic en_i, inout int cnt,
                         inout logic [3:0] so, inout logic v, inout logic ch);
        logic [3:0] tail;
        tail = (e - d + 1 >= 1) ? (hist[e - d + 1] & mask) : 4'd0;
        v  = 1'b0;
        ch = 1'b0;
        if (s) begin
            cnt = 0;
        end else if (en_i) begin
            cnt = cnt + 1;
            if (cnt % r == 0) begin
                v  = 1'b1;
                ch = (tail != so);
                so = tail;
            end
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        cnt_a = 0; cnt_b = 0;
        mso_a = '0; mso_b = '0;
        mv_a = 0; mv_b = 0; mch_a = 0; mch_b = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/a.sel_out"},     32'(so_a), 32'(mso_a));
        check({tag, "/a.out_valid"},   32'(v_a),  32'(mv_a));
        check({tag, "/a.sel_changed"}, 32'(ch_a), 32'(mch_a));
        check({tag, "/a.phase"},       32'(ph_a), 32'(cnt_a % 3));
        check({tag, "/b.sel_out"},     32'(so_b), 32'(mso_b));
        check({tag, "/b.out_valid"},   32'(v_b),  32'(mv_b));
        check({tag, "/b.sel_changed"}, 32'(ch_b), 32'(mch_b));
        check({tag, "/b.phase"},       32'(ph_b), 32'(cnt_b % 5));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/a.sel_out"},     32'(so_a), 32'd0);
        check({tag, "/a.out_valid"},   32'(v_a),  32'd0);
        check({tag, "/a.sel_changed"}, 32'(ch_a), 32'd0);
        check({tag, "/a.phase"},       32'(ph_a), 32'd0);
        check({tag, "/b.sel_out"},     32'(so_b), 32'd0);
        check({tag, "/b.out_valid"},   32'(v_b),  32'd0);
        check({tag, "/b.sel_changed"}, 32'(ch_b), 32'd0);
        check({tag, "/b.phase"},       32'(ph_b), 32'd0);
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, compare 1 time unit later, return at the next falling edge.
    task automatic step(input string tag, input logic s, input logic en_i, input logic [3:0] d);
        sync   = s;
        en     = en_i;
        sel_in = d;
        @(posedge clk);
        edge_n++;
        hist[edge_n] = d;
        model(3, 2, 4'h3, edge_n, s, en_i, cnt_a, mso_a, mv_a, mch_a);
        model(5, 3, 4'hF, edge_n, s, en_i, cnt_b, mso_b, mv_b, mch_b);
        #1;
        check_all(tag);
        $display("step %-8s edge=%0d en=%0b sync=%0b sel_in=%h | a: so=%h v=%0b ch=%0b ph=%0d | b: so=%h v=%0b ch=%0b ph=%0d",
                 tag, edge_n, en_i, s, d, so_a, v_a, ch_a, ph_a, so_b, v_b, ch_b, ph_b);
        @(negedge clk);
    endtask

    initial begin
        reset_L = 1'b0;
        en      = 1'b0;
        sync    = 1'b0;
        sel_in  = '0;
        model_reset();

        #3;
        check_zero("reset");
        @(negedge clk);
        reset_L = 1'b1;

        // Constant selector from release: samples at edges 3,6,9 (A)
        for (int i = 0; i < 10; i++) step("hold1", 1'b0, 1'b1, 4'h1);

        // Stepping selector
        for (int i = 0; i < 8; i++) step("ramp", 1'b0, 1'b1, 4'(i));

        // Sync while configuration A sits at its last phase
        for (int i = 0; i < 3 && (cnt_a % 3) != 2; i++) step("pre_sync", 1'b0, 1'b1, 4'(i + 5));
        step("sync", 1'b1, 1'b1, 4'h9);
        for (int i = 0; i < 4; i++) step("post_syn", 1'b0, 1'b1, 4'(12 - i));

        // Enable low for 4 cycles with A at phase 1
        for (int i = 0; i < 3 && (cnt_a % 3) != 1; i++) step("pre_en", 1'b0, 1'b1, 4'hA);
        for (int i = 0; i < 4; i++) step("en_low", 1'b0, 1'b0, 4'(3 + i));
        for (int i = 0; i < 6; i++) step("en_high", 1'b0, 1'b1, 4'(7 - i));

        // Sync with enable low
        step("sync_dis", 1'b1, 1'b0, 4'h6);
        for (int i = 0; i < 6; i++) step("resume", 1'b0, 1'b1, 4'(i * 3));

        // Randomised traffic
        for (int i = 0; i < 250; i++) begin
            step("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0),
                 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset pulse between edges
        #2;
        reset_L = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("in_rst");
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) step("post_rst", 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 40; i++) begin
            step("random2", ($urandom_range(0, 14) == 0), ($urandom_range(0, 5) != 0),
                 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
